dp_robertson: RTL

//  Datapath for Robertson signed (two's complement) multiplication; responder side of the
//  c[7:0]/q0/count control interface driven by the Robertson control unit.
//  - Executes one micro-operation per asserted control bit.
//  - Returns the status bits q0 and count to the control unit.
//  - Multiplicand, then multiplier, are loaded from inbus.
//  - Product is returned on outbus in two beats (A, then Q).

---
 rtl/dp_robertson.sv | 70 +++++++
 1 files changed

// File: rtl/dp_robertson.sv
// Datapath for Robertson two's-complement multiplication. Executes the micro-ops
// strobed on c[7:0] and reports q0/count back to the control unit.
module dp_robertson #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       c,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             q0,
  output logic             count
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a, q, m;
  logic             f;
  logic [CW-1:0]    cnt;

  logic             arith, shift;
  logic [WIDTH-1:0] a_add, a_sub;

  // Loads outrank the arithmetic step, which in turn blocks the shift.
  assign arith = c[2] & ~c[0] & ~c[1];
  assign shift = c[3] & ~c[2] & ~c[1] & ~c[0];
  assign a_add = a + m;
  assign a_sub = a + ~m + WIDTH'(1);

  assign q0    = q[0];
  assign count = (cnt == CW'(WIDTH-2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      q         <= '0;
      m         <= '0;
      f         <= 1'b0;
      cnt       <= '0;
      outbus    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (c[0]) begin
        m   <= inbus;
        a   <= '0;
        f   <= 1'b0;
        cnt <= '0;
      end else begin
        if (c[4]) cnt <= cnt + CW'(1);
        if (arith) begin
          a <= c[5] ? a_sub : a_add;
          // F latches once a negative multiplicand has been added in.
          if (!c[5]) f <= f | (m[WIDTH-1] & q[0]);
        end else if (shift) begin
          a <= {f, a[WIDTH-1:1]};
        end
      end

      if (c[1])               q    <= inbus;
      else if (arith && c[5]) q[0] <= 1'b0;
      else if (shift)         q    <= {a[0], q[WIDTH-1:1]};

      if (c[6])      outbus <= a;
      else if (c[7]) outbus <= q;
      out_valid <= c[6] | c[7];
    end
  end

endmodule
